// File: rtl/mult8_sequencer.sv
// Purpose: unsigned 8x8 multiply built from four 4x4 multiplier handshakes, with a per-phase watchdog.
// Latency: 17 cycles from accepted start to done_o with a 1-cycle acknowledging multiplier.
// Backpressure: start_i is only accepted in IDLE; each step waits on the four-phase en/fim handshake.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   start_i, a_i, b_i       request and operands (latched when the start is accepted)
//   busy_o, done_o          not-idle flag, one-cycle end-of-operation pulse
//   error_o, result_o       sticky timeout flag, last successful product
//   mul_a_o, mul_b_o        operand nibbles to the 4x4 multiplier
//   mul_en_o, mul_y_i       request and returned 4x4 product
//   mul_fim_i               multiplier acknowledge
module mult8_sequencer #(
    parameter int TIMEOUT  = 255,
    parameter int TO_WIDTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [15:0] result_o,
    output logic [3:0]  mul_a_o,
    output logic [3:0]  mul_b_o,
    output logic        mul_en_o,
    input  logic [7:0]  mul_y_i,
    input  logic        mul_fim_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RELEASE,
        S_DONE,
        S_ERR
    } state_t;

    // Abort on the edge where the count of waiting cycles would reach TIMEOUT.
    localparam logic [TO_WIDTH-1:0] WD_LAST = TO_WIDTH'(TIMEOUT - 1);
    localparam logic [TO_WIDTH-1:0] WD_ONE  = TO_WIDTH'(1);

    state_t              state;
    state_t              state_nxt;
    logic [7:0]          a_q;
    logic [7:0]          b_q;
    logic [1:0]          k_q;
    logic [15:0]         acc_q;
    logic [15:0]         result_q;
    logic [TO_WIDTH-1:0] wd_q;
    logic                error_q;

    logic                wd_expired;
    logic [3:0]          nib_a;
    logic [3:0]          nib_b;
    logic [15:0]         pp;

    assign wd_expired = (wd_q == WD_LAST);

    // Step k selects the nibble pair; the middle two steps share the 4-bit shift.
    always_comb begin
        nib_a = (k_q[1]) ? a_q[7:4] : a_q[3:0];
        nib_b = (k_q[0]) ? b_q[7:4] : b_q[3:0];
        case (k_q)
            2'd0:    pp = {8'd0, mul_y_i};
            2'd3:    pp = {mul_y_i, 8'd0};
            default: pp = {4'd0, mul_y_i, 4'd0};
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_i) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (mul_fim_i)       state_nxt = S_RELEASE;
                else if (wd_expired) state_nxt = S_ERR;
            end
            S_RELEASE: begin
                // Never re-request while fim is still high (four-phase handshake).
                if (!mul_fim_i)      state_nxt = (k_q == 2'd3) ? S_DONE : S_ISSUE;
                else if (wd_expired) state_nxt = S_ERR;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand latch, accumulator, step counter, watchdog, result and error flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            wd_q     <= '0;
            error_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        acc_q   <= '0;
                        k_q     <= '0;
                        wd_q    <= '0;
                        error_q <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (mul_fim_i) begin
                        acc_q <= acc_q + pp;
                        wd_q  <= '0;
                    end else begin
                        wd_q <= wd_q + WD_ONE;
                        if (wd_expired) error_q <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!mul_fim_i) begin
                        wd_q <= '0;
                        // Result is loaded on the edge into DONE so it is valid alongside done_o.
                        if (k_q == 2'd3) result_q <= acc_q;
                        else             k_q      <= k_q + 2'd1;
                    end else begin
                        wd_q <= wd_q + WD_ONE;
                        if (wd_expired) error_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state so reset forces them low without a clock edge.
    always_comb begin
        busy_o   = (state != S_IDLE);
        done_o   = (state == S_DONE) || (state == S_ERR);
        mul_en_o = (state == S_ISSUE);
        mul_a_o  = 4'd0;
        mul_b_o  = 4'd0;
        if (state == S_ISSUE) begin
            mul_a_o = nib_a;
            mul_b_o = nib_b;
        end
        error_o  = error_q;
        result_o = result_q;
    end

endmodule

// File: tb/tb_mult8_sequencer.sv
module tb_mult8_sequencer;

    localparam int TO = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a = 8'd0;
    logic [7:0]  b = 8'd0;
    logic        busy_o, done_o, error_o, mul_en_o;
    logic [15:0] result_o;
    logic [3:0]  mul_a_o, mul_b_o;
    logic [7:0]  mul_y;
    logic        mul_fim;

    mult8_sequencer #(.TIMEOUT(TO), .TO_WIDTH(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .start_i   (start),
        .a_i       (a),
        .b_i       (b),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .error_o   (error_o),
        .result_o  (result_o),
        .mul_a_o   (mul_a_o),
        .mul_b_o   (mul_b_o),
        .mul_en_o  (mul_en_o),
        .mul_y_i   (mul_y),
        .mul_fim_i (mul_fim)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- multiplier model ----------------
    bit         slow = 1'b0;
    bit         stuck = 1'b0;
    logic [3:0] dly;
    logic [3:0] cnt;
    int         hs;
    logic [3:0] thr;
    assign thr = slow ? dly : 4'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_fim <= 1'b0;
            mul_y   <= 8'd0;
            cnt     <= 4'd0;
            dly     <= 4'd3;
            hs      <= 0;
        end else begin
            if (!busy_o) hs <= 0;
            if (mul_en_o && !mul_fim) begin
                if (stuck && hs == 1) begin
                    cnt <= cnt;
                end else if (cnt >= thr) begin
                    mul_fim <= 1'b1;
                    mul_y   <= {4'd0, mul_a_o} * {4'd0, mul_b_o};
                    cnt     <= 4'd0;
                    hs      <= hs + 1;
                    dly     <= 4'($urandom_range(1, 8));
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end else if (!mul_en_o && mul_fim) begin
                if (cnt >= thr) begin
                    mul_fim <= 1'b0;
                    cnt     <= 4'd0;
                    dly     <= 4'($urandom_range(1, 8));
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [15:0] res;
        logic        err;
        int          start_cyc;
        int          lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] pairs[$];
    int         checks = 0;
    int         failures = 0;
    int         done_cnt = 0;
    logic [15:0] last_good = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output monitor: pops one expectation per done pulse.
    exp_t e;
    logic en_d = 1'b0;
    always @(negedge clk) begin
        if (rst_n && mul_en_o && !en_d) begin
            pairs.push_back({mul_a_o, mul_b_o});
            chk("en_rise_while_fim", {31'd0, mul_fim}, 32'd0);
        end
        en_d = mul_en_o;
        if (rst_n && done_o) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done_o=1 expected no pending operation (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("result", {16'd0, result_o}, {16'd0, e.res});
                chk("error", {31'd0, error_o}, {31'd0, e.err});
                if (e.lat >= 0) chk("latency", cyc - e.start_cyc, e.lat);
                if (e.err) chk("en_in_err", {31'd0, mul_en_o}, 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic launch(input logic [7:0] x, input logic [7:0] y, input logic [15:0] res,
                          input bit err, input int lat, output int c0);
        exp_t n;
        @(negedge clk);
        n.res = err ? last_good : res;
        n.err = err;
        n.start_cyc = cyc;
        n.lat = lat;
        if (!err) last_good = res;
        sb.push_back(n);
        c0 = cyc;
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0, input string name);
        int k;
        for (k = 0; k < 400; k++) begin
            if (done_cnt > n0) break;
            @(negedge clk);
        end
        if (done_cnt <= n0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no done_o expected done within 400 cycles", name);
        end
    endtask

    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [15:0] res,
                          input bit err, input int lat, input string name);
        int n0;
        int c0;
        n0 = done_cnt;
        launch(x, y, res, err, lat, c0);
        wait_done(n0, name);
        @(negedge clk);
    endtask

    logic [7:0] exp_pairs[4];

    initial begin
        int n0;
        int c0;
        logic [7:0] rx, ry;

        // Reset state
        #2;
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_error", {31'd0, error_o}, 32'd0);
        chk("rst_en", {31'd0, mul_en_o}, 32'd0);
        chk("rst_result", {16'd0, result_o}, 32'd0);
        chk("rst_nibbles", {24'd0, mul_a_o, mul_b_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic product with nibble sequence and 17-cycle latency
        pairs.delete();
        run_op(8'h0A, 8'h0C, 16'h0078, 1'b0, 17, "basic");
        exp_pairs = '{8'hAC, 8'hA0, 8'h0C, 8'h00};
        chk("basic_pulses", pairs.size(), 4);
        if (pairs.size() == 4)
            for (int i = 0; i < 4; i++) chk("basic_nibbles", {24'd0, pairs[i]}, {24'd0, exp_pairs[i]});

        // Extremes
        run_op(8'hFF, 8'hFF, 16'hFE01, 1'b0, 17, "ff_ff");
        run_op(8'h00, 8'hB7, 16'h0000, 1'b0, 17, "zero");
        run_op(8'h80, 8'h02, 16'h0100, 1'b0, 17, "pow2");

        // Ignored starts at relative cycles 3 and 17
        n0 = done_cnt;
        launch(8'h12, 8'h34, 16'h03A8, 1'b0, 17, c0);
        while (cyc - c0 < 19) begin
            @(negedge clk);
            a = 8'hFF;
            b = 8'hFF;
            start = ((cyc - c0) == 3) || ((cyc - c0) == 17);
        end
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("ignored_busy", {31'd0, busy_o}, 32'd0);
        chk("ignored_done_count", done_cnt, n0 + 1);

        // Stuck acknowledge on step k1
        stuck = 1'b1;
        run_op(8'h55, 8'h66, 16'h0000, 1'b1, -1, "stuck");
        stuck = 1'b0;
        repeat (3) @(negedge clk);
        chk("error_sticky", {31'd0, error_o}, 32'd1);
        chk("stuck_result_kept", {16'd0, result_o}, 32'h03A8);
        n0 = done_cnt;
        launch(8'h21, 8'h03, 16'h0063, 1'b0, 17, c0);
        chk("error_cleared", {31'd0, error_o}, 32'd0);
        wait_done(n0, "after_err");
        @(negedge clk);

        // Reset mid-operation
        n0 = done_cnt;
        @(negedge clk);
        c0 = cyc;
        a = 8'h77;
        b = 8'h99;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc - c0 < 7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_en", {31'd0, mul_en_o}, 32'd0);
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        chk("midrst_result", {16'd0, result_o}, 32'd0);
        last_good = 16'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_no_done", done_cnt, n0);
        run_op(8'h03, 8'h05, 16'h000F, 1'b0, 17, "after_rst");

        // Random pairs against the reference product
        for (int i = 0; i < 200; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            run_op(rx, ry, {8'd0, rx} * {8'd0, ry}, 1'b0, 17, "random");
        end

        // Slow multiplier
        slow = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            run_op(rx, ry, {8'd0, rx} * {8'd0, ry}, 1'b0, -1, "slow");
        end
        slow = 1'b0;

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL global_timeout: got no completion expected finish before 2ms");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mult8_sequencer.md
# mult8_sequencer

Sequencer that computes an unsigned 8x8-bit product by time-sharing the existing 4x4-bit multiplier (`mult_4bits`) over four enable/fim handshakes, accumulating shifted partial products into a 16-bit result. It sits between the register/bus front end, which drives `start_i` and the operands, and the multiplier's A/B/enable/Y/fim port. It also adds a watchdog so that a stalled multiplier can never hang the bus.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent waiting in one handshake phase before abort.
- `TO_WIDTH`, default 8: counter width; must satisfy 2^TO_WIDTH > TIMEOUT.
- `clk_i`  in  1  single clock; all logic is on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  request a multiplication; sampled only in IDLE.
- `a_i`  in  8  operand A; latched when the start is accepted.
- `b_i`  in  8  operand B; latched when the start is accepted.
- `busy_o`  out  1  high whenever the state is not IDLE.
- `done_o`  out  1  one-cycle pulse at the end of an operation, on success or error.
- `error_o`  out  1  sticky timeout flag; cleared on the next accepted start.
- `result_o`  out  16  last successful product; held between operations.
- `mul_a_o`  out  4  operand nibble A to `mult_4bits`.
- `mul_b_o`  out  4  operand nibble B to `mult_4bits`.
- `mul_en_o`  out  1  multiplier enable (request).
- `mul_y_i`  in  8  4x4 product from the multiplier.
- `mul_fim_i`  in  1  multiplier completion (acknowledge).

## Operation
- **States:** IDLE, ISSUE, RELEASE, DONE, ERR.
- **IDLE:**
  - `start_i`=1 latches `a_i`/`b_i`, clears the accumulator, clears step k to 0, clears `error_o`, then goes to ISSUE.
  - `start_i` is ignored in every other state.
- **Step k drives `mul_a_o`/`mul_b_o` as follows:**
  - k0: A[3:0]·B[3:0], shift 0.
  - k1: A[3:0]·B[7:4], shift 4.
  - k2: A[7:4]·B[3:0], shift 4.
  - k3: A[7:4]·B[7:4], shift 8.
- **ISSUE:**
  - `mul_en_o`=1; nibbles are held stable.
  - On `mul_fim_i`=1: acc ← acc + ({8'd0,`mul_y_i`} << shift), computed 16-bit; then go to RELEASE.
- **RELEASE:**
  - `mul_en_o`=0.
  - On `mul_fim_i`=0: if k==3 go to DONE, else k ← k+1 and go to ISSUE.
  - This is a four-phase handshake: a new request is never raised while fim is still high.
- **DONE:**
  - `result_o` ← acc; `done_o`=1 for this one cycle; then IDLE.
- **Watchdog:**
  - The counter clears on entry to ISSUE and to RELEASE, and increments each cycle spent waiting.
  - Reaching TIMEOUT goes to ERR.
- **ERR:**
  - `mul_en_o`=0, `error_o` ← 1, `done_o`=1 for one cycle, `result_o` unchanged; then IDLE.
- **Arithmetic:** unsigned only. The maximum is 255·255 = 0xFE01, so the 16-bit accumulator cannot overflow.
- **`mul_a_o`/`mul_b_o` outside ISSUE:** don't-care to the multiplier; they drive 0 in IDLE.

## Timing
- **Reset values** (asynchronous, immediate):
  - state IDLE.
  - `busy_o`, `done_o`, `error_o`, `mul_en_o` = 0.
  - `result_o` = 0x0000.
  - `mul_a_o`/`mul_b_o` = 0.
  - k, acc, watchdog counter = 0.
- **Reset mid-operation:** `mul_en_o` drops in the same instant and the operation is discarded; no `done_o` is produced.
- **Start accepted at cycle 0:** `busy_o`=1 and `mul_en_o`=1 from cycle 1.
- **Partial-product sampling:** on the edge where ISSUE sees fim=1. `mul_en_o` falls in the next cycle.
- **Reference latency:** with a multiplier model where `mul_fim_i`(t) = `mul_en_o`(t−1), each step takes 4 cycles and `done_o` is high in cycle 17.
- **`result_o`:** updates in the same cycle that `done_o` rises.
- **IDLE return:** `busy_o` falls the cycle after DONE/ERR; a start is accepted from that cycle on.
- **`start_i` during DONE/ERR:** not accepted.
- **`mul_fim_i` already high when ISSUE is entered:** counts as the acknowledge; the bus side guarantees the multiplier is idle at start.

## Test plan
- **Basic product:** A=0x0A, B=0x0C, start at cycle 0 with the 1-cycle fim model -> `done_o` in cycle 17, `result_o`=0x0078, `error_o`=0, exactly four `mul_en_o` pulses with nibble pairs (A,C), (A,0), (0,C), (0,0).
- **Extremes:**
  - 0xFF×0xFF -> 0xFE01.
  - 0x00×0xB7 -> 0x0000.
  - 0x80×0x02 -> 0x0100.
  - Random 200 pairs against a reference model.
- **Ignored start:** `start_i` pulsed with new operands at cycles 3 and 17 of a 0x12×0x34 operation -> `result_o`=0x03A8; the second request is not accepted until the start is raised again in IDLE.
- **Stuck acknowledge:** `mul_fim_i` held 0 during step k1, TIMEOUT=10 -> ERR, `done_o` and `error_o`=1, `mul_en_o`=0, `result_o` keeps the previous value. A following good start clears `error_o`.
- **Reset mid-operation:** `rst_i` low at cycle 7 -> `mul_en_o`, `busy_o`, `result_o` read 0 without a clock edge. After release, a 0x03×0x05 operation gives 0x000F.
- **Slow multiplier:** fim delayed by 1–8 random cycles on rise and fall -> correct result, no `mul_en_o` rise while `mul_fim_i`=1.
